// File: rtl/stage4_defast_seq_ctrl.sv
// stage4_defast_seq_ctrl: sequencer and PID1/MC1/MT1 dictionary owner for the
// stage-4 FAST de-templating datapath. It takes a group of up to three lanes,
// presents them one at a time to a single combinational decoder, and writes
// each decoded header back into the dictionary so copy fields chain across
// lanes and groups.
// Optional feature macro: STAGE4_DEFAST_ERRCNT_EN (saturating rejected-lane counter).
module stage4_defast_seq_ctrl #(
  parameter int FAST_W   = 344,
  parameter int MSG_W    = 280,
  parameter int PMAP_LSB = 328,
  parameter int FLD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_lane_vld,
  input  logic [FAST_W-1:0] in_fast_1,
  input  logic [FAST_W-1:0] in_fast_2,
  input  logic [FAST_W-1:0] in_fast_3,
  output logic [FAST_W-1:0] dec_fast,
  output logic [FLD_W-1:0]  field_PID1,
  output logic [FLD_W-1:0]  field_MC1,
  output logic [FLD_W-1:0]  field_MT1,
  input  logic [MSG_W-1:0]  dec_msg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MSG_W-1:0]  out_message,
  output logic              err_pulse,
  output logic [15:0]       err_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state_q, state_d;
  logic [2:0]                   pend_q, pend_d;
  logic [2:0][FAST_W-1:0]       lane_q, lane_d;
  logic [FAST_W-1:0]            dec_fast_q, dec_fast_d;
  logic                         out_valid_q, out_valid_d;
  logic [MSG_W-1:0]             out_message_q, out_message_d;
  logic [FLD_W-1:0]             pid1_q, pid1_d, mc1_q, mc1_d, mt1_q, mt1_d;
  logic                         err_pulse_q, err_pulse_d;

  logic       step, lane_ok;
  logic [2:0] sel_oh, pend_nxt, nxt_oh, in_oh;

  // One-hot mux of the three lanes; one-hot selects avoid out-of-range indexing.
  function automatic logic [FAST_W-1:0] pick(input logic [2:0] oh,
                                             input logic [2:0][FAST_W-1:0] l);
    return ({FAST_W{oh[0]}} & l[0]) | ({FAST_W{oh[1]}} & l[1]) |
           ({FAST_W{oh[2]}} & l[2]);
  endfunction

  // Next-state, lane sequencing, dictionary write-back and output stream.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    lane_d        = lane_q;
    dec_fast_d    = dec_fast_q;
    out_valid_d   = out_valid_q;
    out_message_d = out_message_q;
    pid1_d        = pid1_q;
    mc1_d         = mc1_q;
    mt1_d         = mt1_q;
    err_pulse_d   = 1'b0;

    step     = !out_valid_q || out_ready;
    // Valid lane: pmap[15] set and the low 12 presence bits all clear.
    lane_ok  = dec_fast_q[PMAP_LSB+15] && (dec_fast_q[PMAP_LSB +: 12] == 12'd0);
    sel_oh   = pend_q & (~pend_q + 3'd1);
    pend_nxt = pend_q & ~sel_oh;
    nxt_oh   = pend_nxt & (~pend_nxt + 3'd1);
    in_oh    = in_lane_vld & (~in_lane_vld + 3'd1);

    // An accepted message leaves the output; a retiring lane may refill it below.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lane_d = {in_fast_3, in_fast_2, in_fast_1};
          pend_d = in_lane_vld;
          if (in_lane_vld != 3'b000) begin
            state_d    = RUN;
            dec_fast_d = pick(in_oh, {in_fast_3, in_fast_2, in_fast_1});
          end
        end
      end
      RUN: begin
        if (step) begin
          if (lane_ok) begin
            out_message_d = dec_msg;
            out_valid_d   = 1'b1;
            pid1_d        = dec_msg[MSG_W-1 -: FLD_W];
            mc1_d         = dec_msg[MSG_W-1-FLD_W -: FLD_W];
            mt1_d         = dec_msg[MSG_W-1-2*FLD_W -: FLD_W];
          end else begin
            err_pulse_d = 1'b1;
          end
          pend_d = pend_nxt;
          // Dictionary write and lane advance share this edge, so the next
          // lane decodes against the updated dictionary.
          if (pend_nxt == 3'b000) state_d = IDLE;
          else dec_fast_d = pick(nxt_oh, lane_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, lane and dictionary registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      lane_q        <= '0;
      dec_fast_q    <= '0;
      out_valid_q   <= 1'b0;
      out_message_q <= '0;
      pid1_q        <= '0;
      mc1_q         <= '0;
      mt1_q         <= '0;
      err_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      lane_q        <= lane_d;
      dec_fast_q    <= dec_fast_d;
      out_valid_q   <= out_valid_d;
      out_message_q <= out_message_d;
      pid1_q        <= pid1_d;
      mc1_q         <= mc1_d;
      mt1_q         <= mt1_d;
      err_pulse_q   <= err_pulse_d;
    end
  end

`ifdef STAGE4_DEFAST_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of rejected lanes; only reset clears it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_pulse_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'd0;
`endif

  assign in_ready    = (state_q == IDLE);
  assign dec_fast    = dec_fast_q;
  assign field_PID1  = pid1_q;
  assign field_MC1   = mc1_q;
  assign field_MT1   = mt1_q;
  assign out_valid   = out_valid_q;
  assign out_message = out_message_q;
  assign err_pulse   = err_pulse_q;

endmodule

// File: tb/tb_stage4_defast_seq_ctrl.sv
// Directed bench for stage4_defast_seq_ctrl. A small decoder stand-in builds
// dec_msg: pmap bits 14/13/12 select "copy from dictionary" for PID1/MC1/MT1,
// otherwise the lane's head bytes are used; the low 256 bits pass through.
module tb_stage4_defast_seq_ctrl;
  localparam int FAST_W = 344, MSG_W = 280, PMAP_LSB = 328, FLD_W = 8;

  logic              clk, rst_n, in_valid, in_ready, out_valid, out_ready, err_pulse;
  logic [2:0]        in_lane_vld;
  logic [FAST_W-1:0] in_fast_1, in_fast_2, in_fast_3, dec_fast;
  logic [FLD_W-1:0]  field_PID1, field_MC1, field_MT1;
  logic [MSG_W-1:0]  dec_msg, out_message;
  logic [15:0]       err_cnt;

  int n_cmp = 0, n_bad = 0, err_seen = 0;
  logic [39:0] got_q[$];

  stage4_defast_seq_ctrl #(.FAST_W(FAST_W), .MSG_W(MSG_W), .PMAP_LSB(PMAP_LSB), .FLD_W(FLD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_fast_1(in_fast_1), .in_fast_2(in_fast_2),
    .in_fast_3(in_fast_3), .dec_fast(dec_fast), .field_PID1(field_PID1),
    .field_MC1(field_MC1), .field_MT1(field_MT1), .dec_msg(dec_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_message(out_message),
    .err_pulse(err_pulse), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  logic [15:0] m_pm;
  logic [23:0] m_hb;
  logic [7:0]  m_p, m_m, m_t;
  always_comb begin
    m_pm    = dec_fast[PMAP_LSB +: 16];
    m_hb    = dec_fast[PMAP_LSB-1 -: 24];
    m_p     = m_pm[14] ? field_PID1 : m_hb[23:16];
    m_m     = m_pm[13] ? field_MC1  : m_hb[15:8];
    m_t     = m_pm[12] ? field_MT1  : m_hb[7:0];
    dec_msg = {m_p, m_m, m_t, dec_fast[MSG_W-25:0]};
  end

  // Record every handshaked message as {header, tag} and every error pulse.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      got_q.push_back({out_message[MSG_W-1 -: 24], out_message[15:0]});
    if (err_pulse) err_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FAST_W-1:0] mk(input logic [15:0] pm, input logic [23:0] hb,
                                           input logic [15:0] tag);
    logic [FAST_W-1:0] l;
    l = '0;
    l[PMAP_LSB +: 16]   = pm;
    l[PMAP_LSB-1 -: 24] = hb;
    l[15:0]             = tag;
    return l;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] v, input logic [FAST_W-1:0] a, b, c);
    int k = 0;
    while (!in_ready && k < 100) begin cyc(); k++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid = 1; in_lane_vld = v; in_fast_1 = a; in_fast_2 = b; in_fast_3 = c;
    cyc();
    in_valid = 0;
  endtask

  task automatic drain();
    int k = 0;
    while (!(in_ready && !out_valid) && k < 100) begin cyc(); k++; end
    if (!(in_ready && !out_valid)) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin cyc(); lat++; end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic expect_msg(input string tag, input logic [39:0] e);
    if (got_q.size() == 0) chk({tag, "_missing"}, 0, 1);
    else chk(tag, got_q.pop_front(), e);
  endtask

  initial begin
    int lat, q0, e0;
    logic [MSG_W-1:0] snap;
    clk = 0; rst_n = 0; in_valid = 0; in_lane_vld = 0; out_ready = 1;
    in_fast_1 = '0; in_fast_2 = '0; in_fast_3 = '0;
    repeat (3) cyc();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_msg_zero", out_message == '0, 1);
    chk("rst_dec_fast_zero", dec_fast == '0, 1);
    chk("rst_dict", {field_PID1, field_MC1, field_MT1}, 0);
    chk("rst_err", {err_pulse, err_cnt}, 0);
    rst_n = 1;
    cyc();

    // T1: single lane, all-copy header from an empty dictionary.
    send(3'b001, mk(16'hF000, 24'h998877, 16'd1), '0, '0);
    wait_valid(lat);
    chk("t1_latency", lat, 1);
    chk("t1_in_ready_back", in_ready, 1);
    drain();
    expect_msg("t1_msg", {24'h000000, 16'd1});
    chk("t1_dict", {field_PID1, field_MC1, field_MT1}, 0);

    // T2: explicit header then all-copy lane chains the dictionary.
    send(3'b011, mk(16'h8000, 24'h112233, 16'd2), mk(16'hF000, 24'h445566, 16'd3), '0);
    drain();
    expect_msg("t2_msg1", {24'h112233, 16'd2});
    expect_msg("t2_msg2", {24'h112233, 16'd3});
    chk("t2_dict", {field_PID1, field_MC1, field_MT1}, 24'h112233);

    // T3: invalid middle lane is dropped; lane 3 copies PID from lane 1.
    e0 = err_seen;
    send(3'b111, mk(16'h8000, 24'hAABBCC, 16'd4), mk(16'h0000, 24'h556677, 16'd5),
         mk(16'hC000, 24'h010203, 16'd6));
    drain();
    expect_msg("t3_msg1", {24'hAABBCC, 16'd4});
    expect_msg("t3_msg3", {24'hAA0203, 16'd6});
    chk("t3_no_extra", got_q.size(), 0);
    chk("t3_err_pulses", err_seen - e0, 1);
    chk("t3_dict", {field_PID1, field_MC1, field_MT1}, 24'hAA0203);
`ifdef STAGE4_DEFAST_ERRCNT_EN
    chk("t3_err_cnt", err_cnt, 1);
`else
    chk("t3_err_cnt", err_cnt, 0);
`endif

    // T4: downstream stall for 5 cycles mid-group.
    out_ready = 0;
    send(3'b111, mk(16'h8000, 24'h101010, 16'd7), mk(16'h8000, 24'h202020, 16'd8),
         mk(16'hA000, 24'h303030, 16'd9));
    wait_valid(lat);
    snap = out_message;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_hold_msg", out_message == snap, 1);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_in_ready_low", in_ready, 0);
    end
    out_ready = 1;
    drain();
    expect_msg("t4_msg1", {24'h101010, 16'd7});
    expect_msg("t4_msg2", {24'h202020, 16'd8});
    expect_msg("t4_msg3", {24'h302030, 16'd9});
    chk("t4_no_extra", got_q.size(), 0);

    // T5: reset between lanes 1 and 2.
    q0 = got_q.size();
    send(3'b111, mk(16'h8000, 24'h0A0B0C, 16'd10), mk(16'h8000, 24'h1A1B1C, 16'd11),
         mk(16'h8000, 24'h2A2B2C, 16'd12));
    wait_valid(lat);
    rst_n = 0;
    #1;
    chk("t5_valid_drop", out_valid, 0);
    chk("t5_dict_zero", {field_PID1, field_MC1, field_MT1}, 0);
    chk("t5_in_ready", in_ready, 1);
    cyc();
    rst_n = 1;
    repeat (6) cyc();
    chk("t5_no_lanes", got_q.size(), q0);
    chk("t5_idle_valid", out_valid, 0);
    chk("t5_idle_ready", in_ready, 1);

    // T6: empty group is consumed with no output and no error.
    q0 = got_q.size(); e0 = err_seen;
    send(3'b000, mk(16'h8000, 24'h777777, 16'd13), '0, '0);
    chk("t6_stay_idle", in_ready, 1);
    repeat (4) cyc();
    chk("t6_no_out", got_q.size(), q0);
    chk("t6_no_err", err_seen - e0, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_dict", {field_PID1, field_MC1, field_MT1}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
